// File: rtl/rv32i_types.sv
// Shared RV32I type definitions.
// Load/store funct3 encodings and access-size helpers.
package rv32i_types;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_e;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_funct3_e;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;

    // Access size comes from the low two funct3 bits for loads and stores.
    function automatic logic [1:0] mem_size(input logic [2:0] funct3);
        return funct3[1:0];
    endfunction

endpackage

// File: rtl/mem_align.sv
// Data-memory alignment: byte enables, store replication,
// load extraction with sign/zero extension, misalign detect.
module mem_align
    import rv32i_types::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  byte_enable,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [31:0] shifted;

    assign shifted = rdata >> {offset, 3'b000};

    // Store lane placement and alignment check by access size.
    always_comb begin
        byte_enable = 4'b1111;
        wdata       = store_data;
        misalign    = 1'b0;
        case (mem_size(funct3))
            SIZE_BYTE: begin
                byte_enable = 4'b0001 << offset;
                wdata       = {4{store_data[7:0]}};
            end
            SIZE_HALF: begin
                byte_enable = 4'b0011 << offset;
                wdata       = {2{store_data[15:0]}};
                misalign    = offset[0];
            end
            default: begin
                misalign = (offset != 2'b00);
            end
        endcase
    end

    // Load lane selection and extension.
    always_comb begin
        load_data = rdata;
        case (funct3)
            LB:      load_data = {{24{shifted[7]}}, shifted[7:0]};
            LBU:     load_data = {24'h0, shifted[7:0]};
            LH:      load_data = {{16{shifted[15]}}, shifted[15:0]};
            LHU:     load_data = {16'h0, shifted[15:0]};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_wb.sv
// Memory / writeback stage: issues data-cache accesses
// and produces one regfile writeback per accepted op.
module mem_wb
    import rv32i_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_mem_read,
    input  logic        in_mem_write,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [4:0]  in_rd,
    input  logic        in_reg_we,
    input  logic [31:0] in_result,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [31:0] dmem_address,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_byte_enable,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_misalign
);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_e;

    state_e      state;
    logic [2:0]  hold_funct3;
    logic [1:0]  hold_offset;
    logic [4:0]  hold_rd;
    logic        hold_we;
    logic        hold_store;

    logic [2:0]  al_funct3;
    logic [1:0]  al_offset;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_load;
    logic        al_misalign;
    logic        is_mem;

    assign in_ready  = (state == IDLE);
    assign is_mem    = in_mem_read | in_mem_write;
    assign al_funct3 = (state == IDLE) ? in_funct3 : hold_funct3;
    assign al_offset = (state == IDLE) ? in_addr[1:0] : hold_offset;

    mem_align u_align (
        .funct3      (al_funct3),
        .offset      (al_offset),
        .store_data  (in_wdata),
        .rdata       (dmem_rdata),
        .byte_enable (al_be),
        .wdata       (al_wdata),
        .load_data   (al_load),
        .misalign    (al_misalign)
    );

    // Accept ops in IDLE, hold the cache request in ACCESS until resp.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            hold_funct3      <= 3'b0;
            hold_offset      <= 2'b0;
            hold_rd          <= 5'b0;
            hold_we          <= 1'b0;
            hold_store       <= 1'b0;
            dmem_read        <= 1'b0;
            dmem_write       <= 1'b0;
            dmem_address     <= 32'h0;
            dmem_wdata       <= 32'h0;
            dmem_byte_enable <= 4'b0;
            wb_valid         <= 1'b0;
            wb_we            <= 1'b0;
            wb_rd            <= 5'b0;
            wb_data          <= 32'h0;
            wb_misalign      <= 1'b0;
        end else begin
            wb_valid    <= 1'b0;
            wb_we       <= 1'b0;
            wb_misalign <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (!is_mem) begin
                            wb_valid <= 1'b1;
                            wb_we    <= in_reg_we && (in_rd != 5'd0);
                            wb_rd    <= in_rd;
                            wb_data  <= in_result;
                        end else if (al_misalign) begin
                            wb_valid    <= 1'b1;
                            wb_misalign <= 1'b1;
                            wb_rd       <= in_rd;
                            wb_data     <= 32'h0;
                        end else begin
                            state            <= ACCESS;
                            dmem_read        <= ~in_mem_write;
                            dmem_write       <= in_mem_write;
                            dmem_address     <= {in_addr[31:2], 2'b00};
                            dmem_wdata       <= al_wdata;
                            dmem_byte_enable <= al_be;
                            hold_funct3      <= in_funct3;
                            hold_offset      <= in_addr[1:0];
                            hold_rd          <= in_rd;
                            hold_we          <= in_reg_we;
                            hold_store       <= in_mem_write;
                        end
                    end
                end
                ACCESS: begin
                    if (dmem_resp) begin
                        state            <= IDLE;
                        dmem_read        <= 1'b0;
                        dmem_write       <= 1'b0;
                        dmem_byte_enable <= 4'b0;
                        wb_valid         <= 1'b1;
                        wb_rd            <= hold_rd;
                        if (hold_store) begin
                            wb_data <= 32'h0;
                        end else begin
                            wb_we   <= hold_we && (hold_rd != 5'd0);
                            wb_data <= al_load;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
